// File: rtl/arp_eth_rx_fifo.sv
// ARP receiver: parses the 28-byte ARP body from an Ethernet payload stream, validates it,
// and queues accepted frames in a first-word-fall-through header FIFO.
module arp_eth_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CHECK_TYPES = 1,
    parameter int FILTER_TPA  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_eth_hdr_valid,
    output logic                          s_eth_hdr_ready,
    input  logic [47:0]                   s_eth_dest_mac,
    input  logic [47:0]                   s_eth_src_mac,
    input  logic [15:0]                   s_eth_type,
    input  logic [DATA_WIDTH-1:0]         s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_eth_payload_axis_tkeep,
    input  logic                          s_eth_payload_axis_tvalid,
    output logic                          s_eth_payload_axis_tready,
    input  logic                          s_eth_payload_axis_tlast,
    input  logic                          s_eth_payload_axis_tuser,
    input  logic [31:0]                   local_ip,
    output logic                          m_frame_valid,
    input  logic                          m_frame_ready,
    output logic [47:0]                   m_eth_dest_mac,
    output logic [47:0]                   m_eth_src_mac,
    output logic [15:0]                   m_eth_type,
    output logic [15:0]                   m_arp_htype,
    output logic [15:0]                   m_arp_ptype,
    output logic [7:0]                    m_arp_hlen,
    output logic [7:0]                    m_arp_plen,
    output logic [15:0]                   m_arp_oper,
    output logic [47:0]                   m_arp_sha,
    output logic [31:0]                   m_arp_spa,
    output logic [47:0]                   m_arp_tha,
    output logic [31:0]                   m_arp_tpa,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          error_header_early_termination,
    output logic                          error_invalid_header,
    output logic                          error_fifo_overflow,
    output logic                          frame_filtered
);

    localparam int PTR_MAX = (28 + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int PTR_W   = $clog2(PTR_MAX + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ_ARP, READ_TAIL} state_t;

    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } frame_t;

    state_t            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              done_q;
    logic [7:0]        body_q [28];
    logic [7:0]        body_d [28];
    logic [47:0]       dest_q, src_q;
    logic [15:0]       type_q;
    logic              early_q, inval_q, ovf_q, filt_q;
    logic              early_d, inval_d, ovf_d, filt_d;
    frame_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q;

    logic [KEEP_WIDTH-1:0] keep;
    logic   beat, end_beat, got27, hdr_bad, tpa_bad, full, push, pop;
    frame_t fr_new, head;

    // Ready outputs are held low while reset is asserted.
    assign s_eth_hdr_ready           = rst_n && (state_q == IDLE);
    assign s_eth_payload_axis_tready = rst_n && (state_q != IDLE);
    assign busy                      = (state_q != IDLE);

    assign keep     = (KEEP_ENABLE != 0) ? s_eth_payload_axis_tkeep : '1;
    assign beat     = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign end_beat = beat && s_eth_payload_axis_tlast;
    assign got27    = done_q || (beat && state_q == READ_ARP &&
                                 ptr_q == PTR_W'(27 / KEEP_WIDTH) && keep[27 % KEEP_WIDTH]);

    // Byte offset o lands on beat o/KEEP_WIDTH, lane o%KEEP_WIDTH.
    always_comb begin
        body_d = body_q;
        if (beat && state_q == READ_ARP) begin
            for (int o = 0; o < 28; o++) begin
                if (ptr_q == PTR_W'(o / KEEP_WIDTH) && keep[o % KEEP_WIDTH])
                    body_d[o] = s_eth_payload_axis_tdata[(o % KEEP_WIDTH)*8 +: 8];
            end
        end
    end

    always_comb begin
        fr_new.dest  = dest_q;
        fr_new.src   = src_q;
        fr_new.etype = type_q;
        fr_new.htype = {body_d[0], body_d[1]};
        fr_new.ptype = {body_d[2], body_d[3]};
        fr_new.hlen  = body_d[4];
        fr_new.plen  = body_d[5];
        fr_new.oper  = {body_d[6], body_d[7]};
        fr_new.sha   = {body_d[8], body_d[9], body_d[10], body_d[11], body_d[12], body_d[13]};
        fr_new.spa   = {body_d[14], body_d[15], body_d[16], body_d[17]};
        fr_new.tha   = {body_d[18], body_d[19], body_d[20], body_d[21], body_d[22], body_d[23]};
        fr_new.tpa   = {body_d[24], body_d[25], body_d[26], body_d[27]};
    end

    assign hdr_bad = (fr_new.hlen != 8'd6) || (fr_new.plen != 8'd4) ||
                     ((CHECK_TYPES != 0) && (fr_new.htype != 16'h0001 || fr_new.ptype != 16'h0800));
    assign tpa_bad = (FILTER_TPA != 0) && (fr_new.tpa != local_ip);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = m_frame_valid && m_frame_ready;

    always_comb begin
        early_d = 1'b0;
        inval_d = 1'b0;
        ovf_d   = 1'b0;
        filt_d  = 1'b0;
        push    = 1'b0;
        if (end_beat) begin
            if (!got27)                      early_d = 1'b1;
            else if (hdr_bad)                inval_d = 1'b1;
            else if (s_eth_payload_axis_tuser) ;
            else if (tpa_bad)                filt_d  = 1'b1;
            else if (full && !pop)           ovf_d   = 1'b1;
            else                             push    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            for (int i = 0; i < 28; i++) body_q[i] <= '0;
            early_q <= 1'b0;
            inval_q <= 1'b0;
            ovf_q   <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            early_q <= early_d;
            inval_q <= inval_d;
            ovf_q   <= ovf_d;
            filt_q  <= filt_d;
            body_q  <= body_d;
            case (state_q)
                IDLE: if (s_eth_hdr_valid) begin
                    dest_q  <= s_eth_dest_mac;
                    src_q   <= s_eth_src_mac;
                    type_q  <= s_eth_type;
                    ptr_q   <= '0;
                    done_q  <= 1'b0;
                    state_q <= READ_ARP;
                end
                READ_ARP: if (beat) begin
                    if (ptr_q != PTR_W'(PTR_MAX)) ptr_q <= ptr_q + 1'b1;
                    done_q <= got27;
                    if (s_eth_payload_axis_tlast) state_q <= IDLE;
                    else if (got27)               state_q <= READ_TAIL;
                end
                READ_TAIL: if (end_beat) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= fr_new;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head           = mem_q[rd_q];
    assign m_frame_valid  = (count_q != '0);
    assign fifo_count     = count_q;
    assign m_eth_dest_mac = head.dest;
    assign m_eth_src_mac  = head.src;
    assign m_eth_type     = head.etype;
    assign m_arp_htype    = head.htype;
    assign m_arp_ptype    = head.ptype;
    assign m_arp_hlen     = head.hlen;
    assign m_arp_plen     = head.plen;
    assign m_arp_oper     = head.oper;
    assign m_arp_sha      = head.sha;
    assign m_arp_spa      = head.spa;
    assign m_arp_tha      = head.tha;
    assign m_arp_tpa      = head.tpa;

    assign error_header_early_termination = early_q;
    assign error_invalid_header           = inval_q;
    assign error_fifo_overflow            = ovf_q;
    assign frame_filtered                 = filt_q;

endmodule

// File: tb/tb_arp_eth_rx_fifo.sv
// Bench for arp_eth_rx_fifo (64-bit datapath, TPA filter on): directed vector table,
// hand-written overflow/reset sequences, and randomized frames against a frame-level model.
module tb_arp_eth_rx_fifo;
    localparam int DW = 64, KW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_eth_hdr_valid = 0, s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac = 0, s_eth_src_mac = 0;
    logic [15:0]   s_eth_type = 0;
    logic [DW-1:0] tdata = 0;
    logic [KW-1:0] tkeep = 0;
    logic          tvalid = 0, tready, tlast = 0, tuser = 0;
    logic [31:0]   local_ip = 0;
    logic          m_frame_valid, m_frame_ready = 0;
    logic [47:0]   m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha;
    logic [15:0]   m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
    logic [7:0]    m_arp_hlen, m_arp_plen;
    logic [31:0]   m_arp_spa, m_arp_tpa;
    logic [2:0]    fifo_count;
    logic          busy, e_early, e_inval, e_ovf, filt;

    arp_eth_rx_fifo #(.DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .FIFO_DEPTH(DEPTH),
                      .CHECK_TYPES(1), .FILTER_TPA(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tkeep(tkeep),
        .s_eth_payload_axis_tvalid(tvalid), .s_eth_payload_axis_tready(tready),
        .s_eth_payload_axis_tlast(tlast), .s_eth_payload_axis_tuser(tuser),
        .local_ip(local_ip),
        .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype), .m_arp_hlen(m_arp_hlen),
        .m_arp_plen(m_arp_plen), .m_arp_oper(m_arp_oper), .m_arp_sha(m_arp_sha),
        .m_arp_spa(m_arp_spa), .m_arp_tha(m_arp_tha), .m_arp_tpa(m_arp_tpa),
        .fifo_count(fifo_count), .busy(busy),
        .error_header_early_termination(e_early), .error_invalid_header(e_inval),
        .error_fifo_overflow(e_ovf), .frame_filtered(filt)
    );

    typedef enum int {R_EARLY, R_INVAL, R_DROP, R_FILT, R_PUSH} res_t;

    typedef struct {
        logic [15:0] htype, ptype;
        logic [7:0]  hlen, plen;
        logic [31:0] tpa, lip;
        int          n;
        bit          usr;
        res_t        exp;
    } vec_t;

    int            checks = 0, errors = 0;
    logic [335:0]  exp_q[$];
    logic [7:0]    fb[48];
    int            fn;
    logic [47:0]   hd_dest, hd_src;
    logic [15:0]   hd_type;
    int            rdy_mode = 1;
    bit            xfer_last = 0;
    res_t          cur_res;
    logic [335:0]  cur_ent;
    logic [3:0]    exp_pulse;
    bit            gaps = 0;

    task automatic chk(input string name, input logic [335:0] act, input logic [335:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [335:0] dut_head();
        return {m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype, m_arp_ptype, m_arp_hlen,
                m_arp_plen, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa};
    endfunction

    // Expected head entry: Ethernet header followed by the 28 body bytes in wire order.
    function automatic logic [335:0] model_entry();
        logic [223:0] b;
        for (int i = 0; i < 28; i++) b[223-8*i -: 8] = fb[i];
        return {hd_dest, hd_src, hd_type, b};
    endfunction

    function automatic res_t classify(input bit usr, input logic [31:0] lip);
        logic [15:0] ht, pt;
        logic [31:0] tp;
        if (fn < 28) return R_EARLY;
        ht = {fb[0], fb[1]};
        pt = {fb[2], fb[3]};
        tp = {fb[24], fb[25], fb[26], fb[27]};
        if (fb[4] != 8'd6 || fb[5] != 8'd4 || ht != 16'h0001 || pt != 16'h0800) return R_INVAL;
        if (usr) return R_DROP;
        if (tp != lip) return R_FILT;
        return R_PUSH;
    endfunction

    task automatic build(input logic [15:0] ht, input logic [15:0] pt, input logic [7:0] hl,
                         input logic [7:0] pl, input logic [47:0] sha, input logic [31:0] tpa,
                         input int n);
        logic [223:0] b;
        b = {ht, pt, hl, pl, 16'h0001 + 16'($urandom_range(0, 1)), sha, $urandom(),
             {16'($urandom()), $urandom()}, tpa};
        for (int i = 0; i < 48; i++) fb[i] = (i < 28) ? b[223-8*i -: 8] : 8'($urandom());
        fn      = n;
        hd_dest = {16'($urandom()), $urandom()};
        hd_src  = {16'($urandom()), $urandom()};
        hd_type = 16'h0806;
    endtask

    // One clock: model pop/push for this edge, then check outputs just after it.
    task automatic step();
        case (rdy_mode)
            0:       m_frame_ready = 1'b0;
            1:       m_frame_ready = 1'b1;
            2:       m_frame_ready = 1'($urandom_range(0, 1));
            default: m_frame_ready = xfer_last;
        endcase
        if (m_frame_ready && exp_q.size() > 0) begin
            chk("head_entry", dut_head(), exp_q[0]);
            exp_q.delete(0);
        end
        exp_pulse = 4'b0000;
        if (xfer_last) begin
            case (cur_res)
                R_EARLY: exp_pulse = 4'b1000;
                R_INVAL: exp_pulse = 4'b0100;
                R_FILT:  exp_pulse = 4'b0001;
                R_PUSH:  if (exp_q.size() >= DEPTH) exp_pulse = 4'b0010;
                         else exp_q.push_back(cur_ent);
                default: exp_pulse = 4'b0000;
            endcase
        end
        @(posedge clk);
        #1;
        chk("pulses", {e_early, e_inval, e_ovf, filt}, exp_pulse);
        chk("fifo_count", fifo_count, exp_q.size());
        chk("m_frame_valid", m_frame_valid, exp_q.size() > 0);
        if (xfer_last) chk("busy_after_last", busy, 0);
        xfer_last = 0;
    endtask

    // Sends the frame held in fb/fn; abort_at >= 0 stops before that beat.
    task automatic send_frame(input res_t exp_res, input bit usr, input int abort_at);
        int nb;
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = hd_dest;
        s_eth_src_mac   = hd_src;
        s_eth_type      = hd_type;
        chk("hdr_ready_idle", s_eth_hdr_ready, 1);
        step();
        s_eth_hdr_valid = 1'b0;
        chk("busy_in_frame", busy, 1);
        nb = (fn + KW - 1) / KW;
        for (int b = 0; b < nb; b++) begin
            if (b == abort_at) return;
            if (gaps && $urandom_range(0, 3) == 0) begin
                tvalid = 1'b0;
                step();
            end
            for (int i = 0; i < KW; i++) begin
                if (b*KW + i < fn) begin
                    tdata[8*i +: 8] = fb[b*KW + i];
                    tkeep[i] = 1'b1;
                end else begin
                    tdata[8*i +: 8] = 8'($urandom());
                    tkeep[i] = 1'b0;
                end
            end
            tvalid = 1'b1;
            tlast  = (b == nb - 1);
            tuser  = tlast ? usr : 1'b0;
            chk("tready_in_frame", tready, 1);
            if (tlast) begin
                xfer_last = 1;
                cur_res   = exp_res;
                cur_ent   = model_entry();
            end
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'hC0A80164, 32'hC0A80164, 28, 0, R_PUSH};
        tbl[1]  = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'h0A000001, 32'h0A000001, 46, 0, R_PUSH};
        tbl[2]  = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'h0A000001, 32'h0A000001, 20, 0, R_EARLY};
        tbl[3]  = '{16'h0001, 16'h0800, 8'd8, 8'd4, 32'h0A000001, 32'h0A000001, 28, 0, R_INVAL};
        tbl[4]  = '{16'h0001, 16'h0800, 8'd6, 8'd6, 32'h0A000001, 32'h0A000001, 30, 0, R_INVAL};
        tbl[5]  = '{16'h0002, 16'h0800, 8'd6, 8'd4, 32'h0A000001, 32'h0A000001, 28, 0, R_INVAL};
        tbl[6]  = '{16'h0001, 16'h86DD, 8'd6, 8'd4, 32'h0A000001, 32'h0A000001, 28, 0, R_INVAL};
        tbl[7]  = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'h0A000001, 32'h0A000001, 40, 1, R_DROP};
        tbl[8]  = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'h0A000002, 32'h0A000001, 28, 0, R_FILT};
        tbl[9]  = '{16'h0001, 16'h0800, 8'd8, 8'd4, 32'h0A000001, 32'h0A000001, 27, 0, R_EARLY};
        tbl[10] = '{16'h0001, 16'h0800, 8'd8, 8'd4, 32'h0A000001, 32'h0A000001, 28, 1, R_INVAL};
        tbl[11] = '{16'h0001, 16'h0800, 8'd6, 8'd4, 32'h0A000002, 32'h0A000001, 36, 1, R_DROP};

        // Reset state while rst_n is held low.
        #3;
        chk("rst_hdr_ready", s_eth_hdr_ready, 0);
        chk("rst_tready", tready, 0);
        chk("rst_valid", m_frame_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {e_early, e_inval, e_ovf, filt}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_mode = 1;
        foreach (tbl[k]) begin
            local_ip = tbl[k].lip;
            build(tbl[k].htype, tbl[k].ptype, tbl[k].hlen, tbl[k].plen,
                  48'h0211_2233_4455 + 48'(k), tbl[k].tpa, tbl[k].n);
            send_frame(tbl[k].exp, tbl[k].usr, -1);
            repeat (2) step();
        end

        // Fill with consumer stalled: fifth frame overflows, then drain in order.
        local_ip = 32'h0A000001;
        rdy_mode = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            build(16'h0001, 16'h0800, 8'd6, 8'd4, 48'hA000_0000_0000 + 48'(i), local_ip, 28);
            send_frame(R_PUSH, 0, -1);
        end
        chk("full_count", fifo_count, DEPTH);
        // Push while full with a pop on the same edge: no overflow.
        rdy_mode = 3;
        build(16'h0001, 16'h0800, 8'd6, 8'd4, 48'hA000_0000_00FF, local_ip, 28);
        send_frame(R_PUSH, 0, -1);
        chk("full_pushpop_count", fifo_count, DEPTH);
        rdy_mode = 1;
        repeat (DEPTH + 2) step();
        chk("drained_count", fifo_count, 0);

        // Reset in the middle of the body (byte 10 is in beat 1).
        rdy_mode = 0;
        build(16'h0001, 16'h0800, 8'd6, 8'd4, 48'h0B00_0000_0001, local_ip, 28);
        send_frame(R_PUSH, 0, -1);
        build(16'h0001, 16'h0800, 8'd6, 8'd4, 48'h0B00_0000_0002, local_ip, 28);
        send_frame(R_PUSH, 0, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", m_frame_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_hdr_ready", s_eth_hdr_ready, 0);
        chk("midrst_tready", tready, 0);
        exp_q.delete();
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_mode = 1;
        build(16'h0001, 16'h0800, 8'd6, 8'd4, 48'h0B00_0000_0003, local_ip, 28);
        send_frame(R_PUSH, 0, -1);
        repeat (2) step();

        // Randomized frames against the frame-level model.
        rdy_mode = 2;
        gaps     = 1;
        for (int f = 0; f < 80; f++) begin
            logic [15:0] ht, pt;
            logic [7:0]  hl, pl;
            logic [31:0] tp;
            int          n;
            bit          usr;
            local_ip = ($urandom_range(0, 3) == 0) ? $urandom() : local_ip;
            ht  = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : 16'h0001;
            pt  = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : 16'h0800;
            hl  = ($urandom_range(0, 9) == 0) ? 8'($urandom())  : 8'd6;
            pl  = ($urandom_range(0, 9) == 0) ? 8'($urandom())  : 8'd4;
            tp  = ($urandom_range(0, 6) == 0) ? $urandom() : local_ip;
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 27) : $urandom_range(28, 46);
            usr = ($urandom_range(0, 9) == 0);
            build(ht, pt, hl, pl, {16'($urandom()), $urandom()}, tp, n);
            send_frame(classify(usr, local_ip), usr, -1);
            repeat ($urandom_range(0, 2)) step();
        end
        rdy_mode = 1;
        repeat (DEPTH + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
